exe_stage: RTL and testbench

Execute stage of the 16-bit RISC pipeline, fed directly by the ID/EXE buffer. Resolves operand forwarding, performs ALU, address, branch and multiply operations, and registers results into an integrated EXE/MEM output register consumed by the memory stage. An iterative shift-add multiplier stalls the front of the pipe while it runs.

---
 rtl/exe_pkg.sv | 43 ++++
 rtl/exe_mul_seq.sv | 73 +++++++
 rtl/exe_stage.sv | 142 ++++++++++++++
 tb/tb_exe_stage.sv | 243 ++++++++++++++++++++++++
 4 files changed

// File: rtl/exe_pkg.sv
// rtl/exe_pkg.sv - shared widths, opcodes, multiplier states and EXE/MEM slot type for exe_stage
package exe_pkg;

  localparam int DATA_W = 16;
  localparam int REG_W  = 3;
  localparam int PC_W   = 6;
  localparam int LB_W   = 8;

  localparam logic [3:0] OP_NOP  = 4'h0;
  localparam logic [3:0] OP_ADD  = 4'h1;
  localparam logic [3:0] OP_SUB  = 4'h2;
  localparam logic [3:0] OP_AND  = 4'h3;
  localparam logic [3:0] OP_OR   = 4'h4;
  localparam logic [3:0] OP_XOR  = 4'h5;
  localparam logic [3:0] OP_SLL  = 4'h6;
  localparam logic [3:0] OP_SRL  = 4'h7;
  localparam logic [3:0] OP_ADDI = 4'h8;
  localparam logic [3:0] OP_LB   = 4'h9;
  localparam logic [3:0] OP_LW   = 4'hA;
  localparam logic [3:0] OP_SW   = 4'hB;
  localparam logic [3:0] OP_BEQ  = 4'hC;
  localparam logic [3:0] OP_MUL  = 4'hD;

  typedef enum logic [1:0] {
    MUL_IDLE = 2'd0,
    MUL_RUN  = 2'd1,
    MUL_DONE = 2'd2
  } mul_state_t;

  // Contents of the EXE/MEM output register; all-zero is a bubble.
  typedef struct packed {
    logic              valid;
    logic              wr_en;
    logic              is_load;
    logic              is_store;
    logic [REG_W-1:0]  rd;
    logic [DATA_W-1:0] result;
    logic [DATA_W-1:0] store_val;
    logic              bra_taken;
    logic [PC_W-1:0]   bra_pc;
  } exe_mem_t;

endpackage

// File: rtl/exe_mul_seq.sv
// rtl/exe_mul_seq.sv - 16-bit iterative shift-add multiplier (built only when EXE_MUL_EN is defined)
`ifdef EXE_MUL_EN
import exe_pkg::*;

module exe_mul_seq (
  input  logic              clock,
  input  logic              reset,
  input  logic              start,
  input  logic [DATA_W-1:0] a,
  input  logic [DATA_W-1:0] b,
  output logic              idle,
  output logic              busy,
  output logic              done,
  output logic [DATA_W-1:0] product
);

  mul_state_t        state, state_next;
  logic [DATA_W-1:0] mcand, mplr, acc;
  logic [3:0]        count;

  always_ff @(posedge clock) begin
    if (reset) begin
      state <= MUL_IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    case (state)
      MUL_IDLE: if (start) state_next = MUL_RUN;
      MUL_RUN:  if (count == 4'd15) state_next = MUL_DONE;
      MUL_DONE: state_next = MUL_IDLE;
      default:  state_next = MUL_IDLE;
    endcase
  end

  // One multiplier bit per RUN cycle; only the low 16 product bits are kept.
  always_ff @(posedge clock) begin
    if (reset) begin
      mcand <= '0;
      mplr  <= '0;
      acc   <= '0;
      count <= '0;
    end else begin
      case (state)
        MUL_IDLE: begin
          if (start) begin
            mcand <= a;
            mplr  <= b;
            acc   <= '0;
            count <= '0;
          end
        end
        MUL_RUN: begin
          if (mplr[0]) acc <= acc + mcand;
          mcand <= mcand << 1;
          mplr  <= mplr >> 1;
          count <= count + 4'd1;
        end
        default: ;
      endcase
    end
  end

  assign idle    = (state == MUL_IDLE);
  assign busy    = (state == MUL_RUN);
  assign done    = (state == MUL_DONE);
  assign product = acc;

endmodule
`endif

// File: rtl/exe_stage.sv
// rtl/exe_stage.sv - execute stage with forwarding and EXE/MEM register; EXE_MUL_EN enables the multiplier
import exe_pkg::*;

module exe_stage (
  input  logic              clock,
  input  logic              reset,
  input  logic              exe_valid,
  input  logic [3:0]        exe_op,
  input  logic [DATA_W-1:0] exe_reg1_val,
  input  logic [DATA_W-1:0] exe_reg2_val,
  input  logic [REG_W-1:0]  exe_rs,
  input  logic [REG_W-1:0]  exe_rt,
  input  logic [REG_W-1:0]  exe_rd,
  input  logic [LB_W-1:0]   exe_lb_const,
  input  logic [DATA_W-1:0] exe_se_const,
  input  logic [PC_W-1:0]   exe_bra_pc,
  input  logic              wb_wr_en,
  input  logic [REG_W-1:0]  wb_rd,
  input  logic [DATA_W-1:0] wb_result,
  output logic              stall,
  output logic              mem_valid,
  output logic              mem_wr_en,
  output logic              mem_is_load,
  output logic              mem_is_store,
  output logic [REG_W-1:0]  mem_rd,
  output logic [DATA_W-1:0] mem_result,
  output logic [DATA_W-1:0] mem_store_val,
  output logic              mem_bra_taken,
  output logic [PC_W-1:0]   mem_bra_pc
);

  exe_mem_t          out_q, out_d;
  logic [DATA_W-1:0] op_a, op_b;
  logic              mul_done;
  logic [DATA_W-1:0] mul_product;
  logic              fwd_ok;

  // Loads are excluded from the own-register path: their data only exists after MEM.
  assign fwd_ok = out_q.valid && out_q.wr_en && !out_q.is_load;

  always_comb begin
    op_a = exe_reg1_val;
    if (exe_rs != '0 && fwd_ok && out_q.rd == exe_rs) begin
      op_a = out_q.result;
    end else if (exe_rs != '0 && wb_wr_en && wb_rd == exe_rs) begin
      op_a = wb_result;
    end
  end

  always_comb begin
    op_b = exe_reg2_val;
    if (exe_rt != '0 && fwd_ok && out_q.rd == exe_rt) begin
      op_b = out_q.result;
    end else if (exe_rt != '0 && wb_wr_en && wb_rd == exe_rt) begin
      op_b = wb_result;
    end
  end

`ifdef EXE_MUL_EN
  logic mul_start, mul_idle, mul_busy;

  assign mul_start = exe_valid && (exe_op == OP_MUL);

  exe_mul_seq u_mul (
    .clock   (clock),
    .reset   (reset),
    .start   (mul_start),
    .a       (op_a),
    .b       (op_b),
    .idle    (mul_idle),
    .busy    (mul_busy),
    .done    (mul_done),
    .product (mul_product)
  );

  assign stall = (mul_idle && mul_start) || mul_busy;
`else
  assign stall       = 1'b0;
  assign mul_done    = 1'b0;
  assign mul_product = '0;
`endif

  always_comb begin
    out_d = '0;
    if (mul_done) begin
      out_d.valid  = 1'b1;
      out_d.wr_en  = 1'b1;
      out_d.rd     = exe_rd;
      out_d.result = mul_product;
    end else if (exe_valid && !stall) begin
      out_d.valid = 1'b1;
      case (exe_op)
        OP_ADD:  begin out_d.wr_en = 1'b1; out_d.result = op_a + op_b; end
        OP_SUB:  begin out_d.wr_en = 1'b1; out_d.result = op_a - op_b; end
        OP_AND:  begin out_d.wr_en = 1'b1; out_d.result = op_a & op_b; end
        OP_OR:   begin out_d.wr_en = 1'b1; out_d.result = op_a | op_b; end
        OP_XOR:  begin out_d.wr_en = 1'b1; out_d.result = op_a ^ op_b; end
        OP_SLL:  begin out_d.wr_en = 1'b1; out_d.result = op_a << op_b[3:0]; end
        OP_SRL:  begin out_d.wr_en = 1'b1; out_d.result = op_a >> op_b[3:0]; end
        OP_ADDI: begin out_d.wr_en = 1'b1; out_d.result = op_a + exe_se_const; end
        OP_LB:   begin out_d.wr_en = 1'b1; out_d.result = {8'h00, exe_lb_const}; end
        OP_LW: begin
          out_d.wr_en   = 1'b1;
          out_d.is_load = 1'b1;
          out_d.result  = op_a + exe_se_const;
        end
        OP_SW: begin
          out_d.is_store  = 1'b1;
          out_d.result    = op_a + exe_se_const;
          out_d.store_val = op_b;
        end
        OP_BEQ: begin
          if (op_a == op_b) begin
            out_d.bra_taken = 1'b1;
            out_d.bra_pc    = exe_bra_pc;
          end
        end
        default: ;
      endcase
      if (out_d.wr_en) out_d.rd = exe_rd;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      out_q <= '0;
    end else begin
      out_q <= out_d;
    end
  end

  assign mem_valid     = out_q.valid;
  assign mem_wr_en     = out_q.wr_en;
  assign mem_is_load   = out_q.is_load;
  assign mem_is_store  = out_q.is_store;
  assign mem_rd        = out_q.rd;
  assign mem_result    = out_q.result;
  assign mem_store_val = out_q.store_val;
  assign mem_bra_taken = out_q.bra_taken;
  assign mem_bra_pc    = out_q.bra_pc;

endmodule

// File: tb/tb_exe_stage.sv
// tb/tb_exe_stage.sv - scoreboard bench for exe_stage; follows EXE_MUL_EN like the RTL
module tb_exe_stage;

  typedef struct packed {
    logic        valid;
    logic        wr_en;
    logic        is_load;
    logic        is_store;
    logic [2:0]  rd;
    logic [15:0] result;
    logic [15:0] store_val;
    logic        bra_taken;
    logic [5:0]  bra_pc;
  } slot_t;

  logic        clock = 1'b0;
  logic        reset;
  logic        exe_valid;
  logic [3:0]  exe_op;
  logic [15:0] exe_reg1_val, exe_reg2_val;
  logic [2:0]  exe_rs, exe_rt, exe_rd;
  logic [7:0]  exe_lb_const;
  logic [15:0] exe_se_const;
  logic [5:0]  exe_bra_pc;
  logic        wb_wr_en;
  logic [2:0]  wb_rd;
  logic [15:0] wb_result;
  logic        stall;
  logic        mem_valid, mem_wr_en, mem_is_load, mem_is_store;
  logic [2:0]  mem_rd;
  logic [15:0] mem_result, mem_store_val;
  logic        mem_bra_taken;
  logic [5:0]  mem_bra_pc;

  int    n_checks = 0;
  int    n_fail   = 0;
  bit    mon_en   = 1'b0;
  slot_t exp_q[$];
  slot_t model_out;

  exe_stage dut (
    .clock(clock), .reset(reset), .exe_valid(exe_valid), .exe_op(exe_op),
    .exe_reg1_val(exe_reg1_val), .exe_reg2_val(exe_reg2_val),
    .exe_rs(exe_rs), .exe_rt(exe_rt), .exe_rd(exe_rd),
    .exe_lb_const(exe_lb_const), .exe_se_const(exe_se_const), .exe_bra_pc(exe_bra_pc),
    .wb_wr_en(wb_wr_en), .wb_rd(wb_rd), .wb_result(wb_result),
    .stall(stall), .mem_valid(mem_valid), .mem_wr_en(mem_wr_en),
    .mem_is_load(mem_is_load), .mem_is_store(mem_is_store), .mem_rd(mem_rd),
    .mem_result(mem_result), .mem_store_val(mem_store_val),
    .mem_bra_taken(mem_bra_taken), .mem_bra_pc(mem_bra_pc)
  );

  always #5 clock = ~clock;

  task automatic chk(input string name, input logic [47:0] act, input logic [47:0] req);
    n_checks++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s actual=%0h required=%0h", name, act, req);
    end
  endtask

  function automatic slot_t dut_slot();
    return {mem_valid, mem_wr_en, mem_is_load, mem_is_store, mem_rd,
            mem_result, mem_store_val, mem_bra_taken, mem_bra_pc};
  endfunction

  // Register value an operand should see: own output slot, then writeback, then register file.
  function automatic logic [15:0] fwd(input logic [2:0] src, input logic [15:0] regval,
                                      input bit wbe, input logic [2:0] wbrd, input logic [15:0] wbres);
    if (src != 0 && model_out.valid && model_out.wr_en && !model_out.is_load && model_out.rd == src)
      return model_out.result;
    if (src != 0 && wbe && wbrd == src) return wbres;
    return regval;
  endfunction

  function automatic slot_t ref_model(input bit v, input logic [3:0] op, input logic [15:0] a,
                                      input logic [15:0] b, input logic [7:0] lb, input logic [15:0] se,
                                      input logic [5:0] bpc, input logic [2:0] rd);
    slot_t       e;
    longint      ua, ub, us, sh;
    e  = '0;
    ua = longint'(a);
    ub = longint'(b);
    us = longint'(se);
    sh = longint'(b[3:0]);
    if (!v) return e;
    e.valid = 1'b1;
    e.wr_en = 1'b1;
    case (op)
      4'h1: e.result = 16'((ua + ub) % 65536);
      4'h2: e.result = 16'((ua - ub + 65536) % 65536);
      4'h3: e.result = a & b;
      4'h4: e.result = a | b;
      4'h5: e.result = a ^ b;
      4'h6: e.result = 16'((ua * (longint'(1) << sh)) % 65536);
      4'h7: e.result = 16'(ua / (longint'(1) << sh));
      4'h8: e.result = 16'((ua + us) % 65536);
      4'h9: e.result = {8'h00, lb};
      4'hA: begin e.is_load = 1'b1; e.result = 16'((ua + us) % 65536); end
      4'hB: begin e.wr_en = 1'b0; e.is_store = 1'b1; e.result = 16'((ua + us) % 65536); e.store_val = b; end
      4'hC: begin e.wr_en = 1'b0; if (a == b) begin e.bra_taken = 1'b1; e.bra_pc = bpc; end end
`ifdef EXE_MUL_EN
      4'hD: e.result = 16'((ua * ub) % 65536);
`endif
      default: e.wr_en = 1'b0;
    endcase
    if (e.wr_en) e.rd = rd;
    return e;
  endfunction

  task automatic issue(input bit v, input logic [3:0] op, input logic [2:0] rs, input logic [2:0] rt,
                       input logic [2:0] rd, input logic [15:0] r1, input logic [15:0] r2,
                       input logic [7:0] lb, input logic [15:0] se, input logic [5:0] bpc,
                       input bit wbe, input logic [2:0] wbrd, input logic [15:0] wbres);
    logic [15:0] a, b;
    slot_t       e;
    @(negedge clock);
    exe_valid = v; exe_op = op; exe_rs = rs; exe_rt = rt; exe_rd = rd;
    exe_reg1_val = r1; exe_reg2_val = r2; exe_lb_const = lb; exe_se_const = se;
    exe_bra_pc = bpc; wb_wr_en = wbe; wb_rd = wbrd; wb_result = wbres;
    a = fwd(rs, r1, wbe, wbrd, wbres);
    b = fwd(rt, r2, wbe, wbrd, wbres);
    e = ref_model(v, op, a, b, lb, se, bpc, rd);
`ifdef EXE_MUL_EN
    if (v && op == 4'hD) begin
      for (int c = 0; c < 17; c++) begin
        #1 chk("stall_mul_busy", 48'(stall), 48'd1);
        model_out = '0;
        @(negedge clock);
      end
    end
`endif
    #1 chk("stall_low", 48'(stall), 48'd0);
    if (e.valid) exp_q.push_back(e);
    model_out = e;
  endtask

  // Monitor: every valid slot is popped against the scoreboard, every bubble must be all-zero.
  always @(posedge clock) begin
    #1;
    if (mon_en) begin
      if (mem_valid) begin
        if (exp_q.size() == 0) begin
          n_checks++;
          n_fail++;
          $display("FAIL unexpected_slot actual=%0h required=none", dut_slot());
        end else begin
          chk("out_slot", 48'(dut_slot()), 48'(exp_q.pop_front()));
        end
      end else begin
        chk("bubble_zero", 48'(dut_slot()), 48'd0);
      end
    end
  end

  initial begin
    logic [15:0] r1, r2;
    reset = 1'b1; exe_valid = 1'b0; exe_op = '0; exe_rs = '0; exe_rt = '0; exe_rd = '0;
    exe_reg1_val = '0; exe_reg2_val = '0; exe_lb_const = '0; exe_se_const = '0;
    exe_bra_pc = '0; wb_wr_en = 1'b0; wb_rd = '0; wb_result = '0;
    model_out = '0;
    repeat (3) @(posedge clock);
    @(negedge clock);
    reset = 1'b0;
    #1;
    chk("reset_slot", 48'(dut_slot()), 48'd0);
    chk("reset_stall", 48'(stall), 48'd0);
    mon_en = 1'b1;

    issue(1, 4'h1, 3'd1, 3'd2, 3'd3, 16'h7FFF, 16'h0001, 8'h0, 16'h0, 6'h0, 0, 3'd0, 16'h0);
    @(posedge clock); #2;
    chk("add_result", 48'(mem_result), 48'h8000);
    chk("add_wr_rd", 48'({mem_wr_en, mem_rd}), 48'({1'b1, 3'd3}));

    issue(1, 4'h2, 3'd3, 3'd2, 3'd4, 16'h0000, 16'h0001, 8'h0, 16'h0, 6'h0, 0, 3'd0, 16'h0);
    @(posedge clock); #2;
    chk("sub_fwd_result", 48'(mem_result), 48'h7FFF);

    issue(1, 4'hC, 3'd5, 3'd6, 3'd0, 16'h1234, 16'h1234, 8'h0, 16'h0, 6'h2A, 0, 3'd0, 16'h0);
    @(posedge clock); #2;
    chk("beq_taken", 48'({mem_bra_taken, mem_bra_pc}), 48'({1'b1, 6'h2A}));
    issue(1, 4'hC, 3'd5, 3'd6, 3'd0, 16'h1234, 16'h1235, 8'h0, 16'h0, 6'h2A, 0, 3'd0, 16'h0);
    @(posedge clock); #2;
    chk("beq_not_taken", 48'({mem_bra_taken, mem_bra_pc}), 48'd0);

    issue(1, 4'hD, 3'd1, 3'd2, 3'd5, 16'h0123, 16'h0010, 8'h0, 16'h0, 6'h0, 0, 3'd0, 16'h0);
    @(posedge clock); #2;
`ifdef EXE_MUL_EN
    chk("mul_product", 48'({mem_wr_en, mem_result}), 48'({1'b1, 16'h1230}));
`else
    chk("mul_as_nop", 48'({mem_valid, mem_wr_en, mem_result}), 48'({1'b1, 1'b0, 16'h0}));
`endif

    issue(1, 4'h8, 3'd0, 3'd0, 3'd2, 16'h0000, 16'h0000, 8'h0, 16'h0005, 6'h0, 0, 3'd0, 16'h0);
    issue(1, 4'h1, 3'd2, 3'd0, 3'd1, 16'h0077, 16'h0000, 8'h0, 16'h0, 6'h0, 1, 3'd2, 16'h0009);
    @(posedge clock); #2;
    chk("fwd_priority", 48'(mem_result), 48'h0005);
    issue(1, 4'h8, 3'd0, 3'd0, 3'd0, 16'h0000, 16'h0000, 8'h0, 16'h0055, 6'h0, 0, 3'd0, 16'h0);
    issue(1, 4'h1, 3'd0, 3'd0, 3'd1, 16'h0011, 16'h0022, 8'h0, 16'h0, 6'h0, 1, 3'd0, 16'h0099);
    @(posedge clock); #2;
    chk("r0_not_fwd", 48'(mem_result), 48'h0033);
    issue(1, 4'h1, 3'd6, 3'd7, 3'd1, 16'h0001, 16'h0002, 8'h0, 16'h0, 6'h0, 1, 3'd6, 16'h0100);
    @(posedge clock); #2;
    chk("wb_fwd", 48'(mem_result), 48'h0102);

`ifdef EXE_MUL_EN
    @(negedge clock);
    exe_valid = 1'b1; exe_op = 4'hD; exe_rs = 3'd1; exe_rt = 3'd2; exe_rd = 3'd4;
    exe_reg1_val = 16'h0003; exe_reg2_val = 16'h0004; wb_wr_en = 1'b0;
    repeat (5) @(negedge clock);
`else
    issue(1, 4'h1, 3'd1, 3'd2, 3'd4, 16'h0003, 16'h0004, 8'h0, 16'h0, 6'h0, 0, 3'd0, 16'h0);
    @(negedge clock);
`endif
    reset = 1'b1;
    exe_valid = 1'b0;
    @(negedge clock);
    reset = 1'b0;
    #1;
    chk("rst_run_slot", 48'(dut_slot()), 48'd0);
    chk("rst_run_stall", 48'(stall), 48'd0);
    model_out = '0;
    repeat (20) @(negedge clock);

    for (int i = 0; i < 300; i++) begin
      r1 = 16'($urandom);
      r2 = ($urandom_range(0, 3) == 0) ? r1 : 16'($urandom);
      issue($urandom_range(0, 9) != 0, 4'($urandom_range(0, 15)),
            3'($urandom_range(0, 7)), 3'($urandom_range(0, 7)), 3'($urandom_range(0, 7)),
            r1, r2, 8'($urandom), 16'($urandom), 6'($urandom),
            $urandom_range(0, 1) == 1, 3'($urandom_range(0, 7)), 16'($urandom));
    end

    @(negedge clock);
    exe_valid = 1'b0;
    repeat (3) @(negedge clock);
    chk("scoreboard_drained", 48'(exp_q.size()), 48'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
